// File: rtl/mic_frame_buffer.sv
// mic_frame_buffer: packs truncated microphone samples into fixed-length frames.
// A writer FSM fills two RAM banks alternately (holding off and counting drops
// when both are full); a reader FSM streams full banks out over a valid/ready
// interface, prefetching through a registered RAM read and a skid register so a
// continuously-ready consumer receives one word per cycle.
module mic_frame_buffer #(
  parameter int FRAME_LEN = 256,
  parameter int SAMPLE_W  = 18,
  parameter int OUT_W     = 16,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic [OUT_W-1:0]    frame_data_out,
  output logic                frame_valid_out,
  input  logic                frame_ready_in,
  output logic                frame_last_out,
  output logic [IDX_W-1:0]    frame_index_out,
  output logic                overrun_out,
  output logic [15:0]         dropped_count_out
);

  localparam int ADDR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } wr_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Writer state
  wr_state_t          wr_state_r, wr_state_s;
  logic [IDX_W-1:0]   wr_idx_r, wr_idx_s;
  logic [1:0]         full_r, full_s;       // bit 0 = bank A, bit 1 = bank B
  logic [1:0]         set_s;
  logic [1:0]         free_s;
  logic               fill_bank_s;
  logic               other_free_s;
  logic               drop_s;
  logic               overrun_r;
  logic [15:0]        drop_cnt_r;

  // RAM ports
  logic               ram_we_s;
  logic [ADDR_W-1:0]  ram_waddr_s;
  logic [OUT_W-1:0]   ram_wdata_s;
  logic [OUT_W-1:0]   mem_r [0:2*FRAME_LEN-1];
  logic [OUT_W-1:0]   rd_data_r;

  // Reader state
  rd_state_t          rd_state_r, rd_state_s;
  logic               rd_bank_r, rd_bank_s;
  logic [IDX_W-1:0]   rd_idx_r, rd_idx_s;
  logic               rd_issue_s;
  logic [ADDR_W-1:0]  rd_addr_s;
  logic               bank_full_s;
  logic               can_issue_s;
  logic [1:0]         pending_s;

  // Read pipeline: F = word arriving from RAM, S = skid, O = output register
  logic               f_valid_r, f_last_r, f_bank_r;
  logic [IDX_W-1:0]   f_idx_r;
  logic               s_valid_r, s_last_r, s_bank_r;
  logic [IDX_W-1:0]   s_idx_r;
  logic [OUT_W-1:0]   s_data_r;
  logic               o_valid_r, o_last_r, o_bank_r;
  logic [IDX_W-1:0]   o_idx_r;
  logic [OUT_W-1:0]   o_data_r;
  logic               accept_s;
  logic               take_o_s;

  // Truncation keeps the top OUT_W bits; the discarded LSBs are deliberately unused.
  assign ram_wdata_s = sample_in[SAMPLE_W-1 -: OUT_W];
  generate
    if (SAMPLE_W > OUT_W) begin : g_trunc
      logic unused_lsbs_s;
      assign unused_lsbs_s = ^sample_in[SAMPLE_W-OUT_W-1:0];
    end
  endgenerate

  assign accept_s     = o_valid_r & frame_ready_in;
  assign free_s       = (accept_s & o_last_r) ? (o_bank_r ? 2'b10 : 2'b01) : 2'b00;
  assign fill_bank_s  = (wr_state_r == FILL_B);
  assign other_free_s = fill_bank_s ? (~full_r[0] | free_s[0]) : (~full_r[1] | free_s[1]);
  assign full_s       = (full_r & ~free_s) | set_s;

  // Writer next-state: store samples, mark banks full, hold off or drop when both banks busy
  always_comb begin
    wr_state_s  = wr_state_r;
    wr_idx_s    = wr_idx_r;
    ram_we_s    = 1'b0;
    ram_waddr_s = {fill_bank_s, wr_idx_r};
    set_s       = 2'b00;
    drop_s      = 1'b0;
    case (wr_state_r)
      FILL_A, FILL_B: begin
        if (sample_valid_in) begin
          ram_we_s = 1'b1;
          if (wr_idx_r == IDX_LAST) begin
            set_s    = fill_bank_s ? 2'b10 : 2'b01;
            wr_idx_s = IDX_ZERO;
            if (other_free_s) begin
              wr_state_s = fill_bank_s ? FILL_A : FILL_B;
            end else begin
              wr_state_s = HOLD;
            end
          end else begin
            wr_idx_s = wr_idx_r + IDX_ONE;
          end
        end else begin
          ram_we_s = 1'b0;
        end
      end
      HOLD: begin
        if (free_s != 2'b00) begin
          // A bank frees this cycle: a coincident sample goes to its index 0.
          wr_state_s = free_s[1] ? FILL_B : FILL_A;
          if (sample_valid_in) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = {free_s[1], IDX_ZERO};
            wr_idx_s    = IDX_ONE;
          end else begin
            wr_idx_s = IDX_ZERO;
          end
        end else if (sample_valid_in) begin
          drop_s = 1'b1;
        end else begin
          drop_s = 1'b0;
        end
      end
      default: begin
        wr_state_s = FILL_A;
        wr_idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Writer registers, bank-full flags and the sticky overrun / saturating drop counter
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_state_r <= FILL_A;
      wr_idx_r   <= IDX_ZERO;
      full_r     <= 2'b00;
      overrun_r  <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      wr_state_r <= wr_state_s;
      wr_idx_r   <= wr_idx_s;
      full_r     <= full_s;
      if (drop_s) begin
        overrun_r <= 1'b1;
        if (drop_cnt_r != 16'hFFFF) begin
          drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Bank RAM: one write per stored sample, one registered read per issued word
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      mem_r[ram_waddr_s] <= ram_wdata_s;
    end
    if (rd_issue_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  // A read may issue only if O and S can absorb every word still outstanding.
  assign pending_s   = {1'b0, o_valid_r} + {1'b0, s_valid_r} + {1'b0, f_valid_r};
  assign can_issue_s = (pending_s - {1'b0, accept_s}) <= 2'd1;
  assign bank_full_s = rd_bank_r ? full_r[1] : full_r[0];
  assign rd_addr_s   = {rd_bank_r, rd_idx_r};

  // Reader next-state: start on the oldest full bank, issue reads in index order,
  // and roll straight into the other bank so back-to-back frames have no gap
  always_comb begin
    rd_state_s = rd_state_r;
    rd_bank_s  = rd_bank_r;
    rd_idx_s   = rd_idx_r;
    rd_issue_s = 1'b0;
    case (rd_state_r)
      IDLE: begin
        if (bank_full_s && can_issue_s) begin
          rd_issue_s = 1'b1;
          rd_state_s = READ;
          rd_idx_s   = rd_idx_r + IDX_ONE;
        end else begin
          rd_issue_s = 1'b0;
        end
      end
      READ: begin
        if (can_issue_s) begin
          rd_issue_s = 1'b1;
          if (rd_idx_r == IDX_LAST) begin
            rd_idx_s   = IDX_ZERO;
            rd_bank_s  = ~rd_bank_r;
            rd_state_s = IDLE;
          end else begin
            rd_idx_s = rd_idx_r + IDX_ONE;
          end
        end else begin
          rd_issue_s = 1'b0;
        end
      end
      default: begin
        rd_state_s = IDLE;
        rd_idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Reader registers and the metadata travelling alongside the RAM read
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_state_r <= IDLE;
      rd_bank_r  <= 1'b0;
      rd_idx_r   <= IDX_ZERO;
      f_valid_r  <= 1'b0;
      f_last_r   <= 1'b0;
      f_bank_r   <= 1'b0;
      f_idx_r    <= IDX_ZERO;
    end else begin
      rd_state_r <= rd_state_s;
      rd_bank_r  <= rd_bank_s;
      rd_idx_r   <= rd_idx_s;
      f_valid_r  <= rd_issue_s;
      if (rd_issue_s) begin
        f_last_r <= (rd_idx_r == IDX_LAST);
        f_bank_r <= rd_bank_r;
        f_idx_r  <= rd_idx_r;
      end else begin
        f_last_r <= f_last_r;
      end
    end
  end

  assign take_o_s = ~o_valid_r | accept_s;

  // Output and skid registers: O advances on acceptance, S catches the in-flight word
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      o_valid_r <= 1'b0;
      o_last_r  <= 1'b0;
      o_bank_r  <= 1'b0;
      o_idx_r   <= IDX_ZERO;
      o_data_r  <= {OUT_W{1'b0}};
      s_valid_r <= 1'b0;
      s_last_r  <= 1'b0;
      s_bank_r  <= 1'b0;
      s_idx_r   <= IDX_ZERO;
      s_data_r  <= {OUT_W{1'b0}};
    end else if (take_o_s) begin
      if (s_valid_r) begin
        o_valid_r <= 1'b1;
        o_last_r  <= s_last_r;
        o_bank_r  <= s_bank_r;
        o_idx_r   <= s_idx_r;
        o_data_r  <= s_data_r;
        s_valid_r <= f_valid_r;
        if (f_valid_r) begin
          s_last_r <= f_last_r;
          s_bank_r <= f_bank_r;
          s_idx_r  <= f_idx_r;
          s_data_r <= rd_data_r;
        end else begin
          s_last_r <= 1'b0;
        end
      end else if (f_valid_r) begin
        o_valid_r <= 1'b1;
        o_last_r  <= f_last_r;
        o_bank_r  <= f_bank_r;
        o_idx_r   <= f_idx_r;
        o_data_r  <= rd_data_r;
        s_valid_r <= 1'b0;
      end else begin
        o_valid_r <= 1'b0;
        o_last_r  <= 1'b0;
      end
    end else begin
      if (!s_valid_r && f_valid_r) begin
        s_valid_r <= 1'b1;
        s_last_r  <= f_last_r;
        s_bank_r  <= f_bank_r;
        s_idx_r   <= f_idx_r;
        s_data_r  <= rd_data_r;
      end else begin
        s_valid_r <= s_valid_r;
      end
    end
  end

  assign frame_data_out    = o_data_r;
  assign frame_valid_out   = o_valid_r;
  assign frame_last_out    = o_last_r;
  assign frame_index_out   = o_idx_r;
  assign overrun_out       = overrun_r;
  assign dropped_count_out = drop_cnt_r;

endmodule

// File: doc/mic_frame_buffer.md
MIC_FRAME_BUFFER -- requirements
Module: mic_frame_buffer

Interface
REQ-001 Parameter FRAME_LEN, default 256, samples per frame; SHALL be a power of two and at least 4.
REQ-002 Parameter SAMPLE_W, default 18, width of the signed mic sample from pmod_mic.
REQ-003 Parameter OUT_W, default 16, width of the signed frame word.
REQ-004 clk_in  input  1  the single system clock; all logic on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 sample_in  input  SAMPLE_W  signed mic sample, two's complement.
REQ-007 sample_valid_in  input  1  one-cycle strobe; sample_in is valid this cycle.
REQ-008 frame_data_out  output  OUT_W  current frame word.
REQ-009 frame_valid_out  output  1  frame_data_out is valid.
REQ-010 frame_ready_in  input  1  consumer accepts the word when high together with frame_valid_out.
REQ-011 frame_last_out  output  1  high with the final word (index FRAME_LEN-1) of a frame.
REQ-012 frame_index_out  output  log2(FRAME_LEN)  index of the current word within its frame.
REQ-013 overrun_out  output  1  sticky flag; set on the first dropped sample, cleared only by reset.
REQ-014 dropped_count_out  output  16  count of dropped samples; saturates at 16'hFFFF.

Function
REQ-015 Conversion SHALL be an arithmetic truncation: word = sample_in[SAMPLE_W-1 : SAMPLE_W-OUT_W], with no rounding.
REQ-016 Storage SHALL be two banks (A and B) of FRAME_LEN words each, held in a synchronous one-cycle-read RAM.
REQ-017 Writer FSM states SHALL be FILL_A, FILL_B and HOLD; reset state is FILL_A with write index 0.
REQ-018 In FILL_x, each sample_valid_in SHALL write the word at the write index and then increment the index.
REQ-019 When FILL_x writes index FRAME_LEN-1, bank x SHALL be marked full and the write index SHALL wrap to 0.
REQ-020 After bank x fills, the writer SHALL go to FILL_other if the other bank is free; otherwise it SHALL go to HOLD.
REQ-021 A sample arriving in HOLD SHALL be dropped; this sets overrun_out and increments dropped_count_out.
REQ-022 Reader FSM states SHALL be IDLE and READ; in IDLE it takes the oldest full bank.
REQ-023 frame_valid_out SHALL rise exactly 2 clock cycles after the sample_valid_in cycle that fills a bank, provided the reader is IDLE.
REQ-024 If the reader is busy, the next frame's first word SHALL follow the previous frame's last accepted word with no idle cycle.
REQ-025 A transfer occurs when frame_valid_out and frame_ready_in are both high; the reader then advances one word.
REQ-026 With frame_ready_in held high, the reader SHALL sustain one word per cycle, using prefetch/skid logic.
REQ-027 While frame_valid_out is high and frame_ready_in is low, frame_data_out, frame_last_out and frame_index_out SHALL hold stable.
REQ-028 Accepting the last word SHALL free its bank in that same cycle.
REQ-029 If the writer is in HOLD when a bank is freed, it SHALL enter FILL of that bank.
REQ-030 Simultaneous event: a sample_valid_in in the cycle the bank is freed SHALL be written to index 0 of the freed bank, not dropped.
REQ-031 Frames SHALL be emitted in the order they were filled; words within a frame SHALL be emitted in index order 0..FRAME_LEN-1.

Reset
REQ-032 On rst_in low, both FSMs SHALL reset asynchronously, both banks SHALL be marked free, and all indices SHALL be 0.
REQ-033 During reset: frame_valid_out=0, frame_last_out=0, frame_data_out=0, frame_index_out=0, overrun_out=0, dropped_count_out=0.
REQ-034 Reset mid-frame SHALL discard all partial and full frames; RAM contents need not be cleared.
REQ-035 The first sample after reset release SHALL be written to bank A, index 0.

Verification (FRAME_LEN=4, SAMPLE_W=18, OUT_W=16)
REQ-036 Reset check: assert rst_in low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
REQ-037 Conversion and latency check.
- Stimulus: ready high; samples 18'h3FFFC, 18'h00004, 18'h1FFFF, 18'h20000.
- Response: valid rises 2 cycles after the 4th sample.
- Words out: 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000, on consecutive cycles.
- Indices 0..3, with last high only on the 4th word.
REQ-038 Backpressure: hold ready low for 10 cycles mid-frame -> data, index and last stable; no word lost or duplicated after ready rises.
REQ-039 Overrun check.
- Stimulus: ready low; feed 12 samples 1..12 (shifted left by 2).
- Response: samples 9-12 dropped; dropped_count_out=4; overrun_out=1.
- Then raise ready: frames {1,2,3,4} then {5,6,7,8} emitted.
- A 13th sample lands in bank A, index 0.
REQ-040 Simultaneous release: writer in HOLD, sample_valid_in coincides with acceptance of the last word -> sample stored at index 0 of the freed bank; dropped_count_out unchanged.
REQ-041 Reset mid-frame: 2 samples written, then reset -> the next 4 samples form the first frame emitted; dropped_count_out=0.
